hazard_stall_ctrl: RTL

- Hazard and stall controller that drives the stall/flush/forward controls consumed by the pipeline registers (FlushE/StallE into DEC_EX stage, etc.).
- Combines RAW forwarding, load-use stall, branch/jump flush, and a sequential bus-wait FSM that freezes the pipeline while an APB/UART transaction in MEM awaits completion.
- Sits alongside the RV32I datapath; the sole source of all Stall*/Flush*/Forward* signals.

---
 rtl/hazard_stall_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central hazard unit for the RV32I pipeline. It is the only source of the
// Stall*/Flush*/Forward* controls used by the pipeline registers, and it
// covers four concerns:
//   * RAW forwarding into EX, with the M stage taking priority over W
//   * load-use stall, which holds F/D and bubbles E
//   * branch/jump flush of D and E
//   * a two-state bus-wait FSM that freezes the whole pipeline while an
//     APB/UART access in MEM is pending, and gives up after TIMEOUT_CYCLES
//
// State, the wait counter and the sticky bus_timeout flag are registered.
// Every other output is combinational from state and inputs.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles is a 32-bit wrapping counter of StallF cycles
//   undefined -> stall_cycles is tied to zero
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [1:0]  LOAD_SRC       = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        transEnM,
  input  logic        trans_done,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        bus_timeout,
  output logic [31:0] stall_cycles
);

  // Timeout limit as an 8-bit value, so it can be compared with the counter.
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        bus_timeout_q;
  logic        bus_timeout_d;

  logic        bus_stall_s;
  logic        load_use_s;
  logic [1:0]  fwd_a_s;
  logic [1:0]  fwd_b_s;

  // Forwarding select for one EX source operand. M is younger than W, so it
  // wins. x0 is never forwarded because it is hard-wired to zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       wr_m,
    input logic       wr_w
  );
    logic [1:0] sel;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Detect RAW and load-use hazards from the register specifiers.
  always_comb begin
    fwd_a_s    = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    fwd_b_s    = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
    load_use_s = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Freeze condition: a new access waiting in IDLE, or an access still
  // waiting in WAIT that has not yet reached the timeout limit.
  always_comb begin
    bus_stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transEnM && !trans_done) begin
          bus_stall_s = 1'b1;
        end else begin
          bus_stall_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!trans_done && (cnt_q != TIMEOUT_LIM)) begin
          bus_stall_s = 1'b1;
        end else begin
          bus_stall_s = 1'b0;
        end
      end
      default: begin
        bus_stall_s = 1'b0;
      end
    endcase
  end

  // Bus-wait FSM next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_timeout_d = bus_timeout_q;
    if (rst) begin
      state_d       = ST_IDLE;
      cnt_d         = 8'd0;
      bus_timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transEnM && !trans_done) begin
            state_d = ST_WAIT;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (trans_done) begin
            state_d = ST_IDLE;
          end else if (cnt_q == TIMEOUT_LIM) begin
            state_d       = ST_IDLE;
            bus_timeout_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Register the FSM state, the counter and the timeout flag.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    cnt_q         <= cnt_d;
    bus_timeout_q <= bus_timeout_d;
  end

  // Pipeline controls. Reset flushes D and E. A bus freeze overrides the
  // load-use and branch effects, so the held branch is re-evaluated after
  // the freeze ends. A taken branch cancels a load-use stall on F and D.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
      if (bus_stall_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = load_use_s && !PCSrcE;
        StallD = load_use_s && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = PCSrcE || load_use_s;
      end
    end
  end

  assign bus_timeout = bus_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Count fetch-stall cycles. The counter wraps naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (rst) begin
      stall_cycles_d = 32'd0;
    end else if (StallF) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Register the stall-cycle counter.
  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
